// File: rtl/lpddr5_dev_model.sv
// lpddr5_dev_model: device-side LPDDR5 command responder with per-bank timing checks,
// one-word-per-beat storage and a fixed CL read return pipe.
module lpddr5_dev_model #(
  parameter int BANK_NUM   = 8,
  parameter int ROW_WIDTH  = 16,
  parameter int COL_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int CL         = 4,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 4,
  parameter int T_RAS      = 10,
  parameter int T_RC       = 14,
  parameter int T_WR       = 4,
  parameter int T_RFC      = 20,
  parameter int T_REFI     = 100,
  localparam int BW        = $clog2(BANK_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [BW-1:0]         cmd_bank,
  input  logic [ROW_WIDTH-1:0]  cmd_row,
  input  logic [COL_WIDTH-1:0]  cmd_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  viol_valid,
  output logic [3:0]            viol_code,
  output logic [BW-1:0]         viol_bank,
  output logic                  ref_overdue,
  output logic [BANK_NUM-1:0]   bank_open
);
  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready and rst is low.
  // cmd_ready only drops during the post-refresh window; anything offered then is ignored, not queued.

  localparam int TW = 8;
  localparam logic [TW-1:0] TMAX  = '1;
  localparam logic [TW-1:0] RCD_T = TW'(T_RCD);
  localparam logic [TW-1:0] RP_T  = TW'(T_RP);
  localparam logic [TW-1:0] RAS_T = TW'(T_RAS);
  localparam logic [TW-1:0] RC_T  = TW'(T_RC);
  localparam logic [TW-1:0] WR_T  = TW'(T_WR);
  localparam int FW = $clog2(T_RFC + 1);
  localparam logic [FW-1:0] RFC_T = FW'(T_RFC);
  localparam int RW = $clog2(T_REFI + 2);
  localparam logic [RW-1:0] REFI_T = RW'(T_REFI);
  localparam int AW = BW + COL_WIDTH;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_RD  = 3'd2;
  localparam logic [2:0] OP_WR  = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;
  localparam logic [2:0] OP_REF = 3'd5;

  typedef enum logic {BANK_CLOSED = 1'b0, BANK_OPEN = 1'b1} bank_state_t;

  bank_state_t                        bank_st [BANK_NUM];
  logic [TW-1:0]                      act_tmr [BANK_NUM];
  logic [TW-1:0]                      pre_tmr [BANK_NUM];
  logic [TW-1:0]                      wr_tmr  [BANK_NUM];
  logic [BANK_NUM-1:0][ROW_WIDTH-1:0] open_row;
  logic [DATA_WIDTH-1:0]              mem [2**AW];
  logic [FW-1:0]                      rfc_cnt;
  logic [RW-1:0]                      ref_cnt;
  logic [CL-1:0]                      pipe_v;
  logic [CL-1:0][DATA_WIDTH-1:0]      pipe_d;

  logic          accept, do_cmd, is_open;
  logic          act_en, rd_en, wr_en, pre_en, ref_en;
  logic [3:0]    code;
  logic [BW-1:0] code_bank, lowest_open;
  logic [AW-1:0] addr;
  logic [TW-1:0] act_t, pre_t, wr_t;
  logic          row_unused;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TMAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) bank_open[b] = (bank_st[b] == BANK_OPEN);
  end

  // Checks are ordered so the lowest violated code wins.
  always_comb begin
    lowest_open = '0;
    for (int b = BANK_NUM - 1; b >= 0; b--) if (bank_open[b]) lowest_open = BW'(b);
    accept    = cmd_valid && cmd_ready && !rst;
    addr      = {cmd_bank, cmd_col};
    act_t     = act_tmr[cmd_bank];
    pre_t     = pre_tmr[cmd_bank];
    wr_t      = wr_tmr[cmd_bank];
    is_open   = bank_open[cmd_bank];
    code      = 4'd0;
    code_bank = cmd_bank;
    if (accept) begin
      case (cmd_op)
        OP_NOP: code = 4'd0;
        OP_ACT: begin
          if (act_t < RC_T)      code = 4'd3;
          else if (pre_t < RP_T) code = 4'd4;
          else if (is_open)      code = 4'd7;
        end
        OP_RD, OP_WR: begin
          if (act_t < RCD_T)     code = 4'd1;
          else if (!is_open)     code = 4'd6;
        end
        OP_PRE: begin
          if (is_open) begin
            if (act_t < RAS_T)     code = 4'd2;
            else if (wr_t < WR_T)  code = 4'd5;
          end
        end
        OP_REF: begin
          if (|bank_open) code = 4'd8;
          code_bank = lowest_open;
        end
        default: code = 4'd9;
      endcase
    end
    do_cmd = accept && (code == 4'd0);
    act_en = do_cmd && (cmd_op == OP_ACT);
    rd_en  = do_cmd && (cmd_op == OP_RD);
    wr_en  = do_cmd && (cmd_op == OP_WR);
    pre_en = do_cmd && (cmd_op == OP_PRE) && is_open;
    ref_en = do_cmd && (cmd_op == OP_REF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        bank_st[b] <= BANK_CLOSED;
        act_tmr[b] <= TMAX;
        pre_tmr[b] <= TMAX;
        wr_tmr[b]  <= TMAX;
      end
      rfc_cnt    <= '0;
      ref_cnt    <= '0;
      pipe_v     <= '0;
      pipe_d     <= '0;
      viol_valid <= 1'b0;
      viol_code  <= 4'd0;
      viol_bank  <= '0;
    end else begin
      for (int b = 0; b < BANK_NUM; b++) begin
        if (act_en && cmd_bank == BW'(b)) begin
          bank_st[b] <= BANK_OPEN;
          act_tmr[b] <= TW'(1);
        end else begin
          act_tmr[b] <= sat_inc(act_tmr[b]);
        end
        if (pre_en && cmd_bank == BW'(b)) begin
          bank_st[b] <= BANK_CLOSED;
          pre_tmr[b] <= TW'(1);
        end else begin
          pre_tmr[b] <= sat_inc(pre_tmr[b]);
        end
        wr_tmr[b] <= (wr_en && cmd_bank == BW'(b)) ? TW'(1) : sat_inc(wr_tmr[b]);
      end
      if (ref_en)               rfc_cnt <= RFC_T;
      else if (rfc_cnt != '0)   rfc_cnt <= rfc_cnt - 1'b1;
      if (ref_en)               ref_cnt <= '0;
      else if (ref_cnt != '1)   ref_cnt <= ref_cnt + 1'b1;
      // Data stages only load on a valid beat, so the last stage holds the previous read.
      pipe_v[0] <= rd_en;
      if (rd_en) pipe_d[0] <= mem[addr];
      for (int k = 1; k < CL; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        if (pipe_v[k-1]) pipe_d[k] <= pipe_d[k-1];
      end
      viol_valid <= (code != 4'd0);
      viol_code  <= code;
      viol_bank  <= (code != 4'd0) ? code_bank : '0;
    end
  end

  // Storage and open rows survive reset; the open row is tracked for debug only since RD/WR ignore it.
  always_ff @(posedge clk) begin
    if (wr_en)  mem[addr] <= wr_data;
    if (act_en) open_row[cmd_bank] <= cmd_row;
  end

  assign row_unused  = ^open_row;
  assign cmd_ready   = (rfc_cnt == '0);
  assign ref_overdue = (ref_cnt > REFI_T);
  assign rd_valid    = pipe_v[CL-1];
  assign rd_data     = pipe_d[CL-1];
endmodule
